// File: rtl/washer_plant_model_pkg.sv
// Shared types and default timing constants for the washing-machine plant model.
//   motor_state_t    : drum motor mode tracked by the plant
//   *_CYCLES_DEF     : default tank capacity and phase durations in clk cycles
package washer_plant_model_pkg;

  localparam int unsigned FILL_CYCLES_DEF = 8;
  localparam int unsigned DET_CYCLES_DEF  = 3;
  localparam int unsigned WASH_CYCLES_DEF = 16;
  localparam int unsigned SPIN_CYCLES_DEF = 12;

  typedef enum logic [2:0] {
    M_STOP    = 3'd0,
    M_WASH    = 3'd1,
    M_WASH_TO = 3'd2,
    M_SPIN    = 3'd3,
    M_SPIN_TO = 3'd4
  } motor_state_t;

endpackage

// File: rtl/washer_plant_model_if.sv
// Actuator/sensor bundle between the wash controller and the plant model.
//   master : controller side, drives actuators, observes sensors
//   slave  : plant side, observes actuators, drives sensors
interface washer_plant_model_if #(
  parameter int unsigned FILL_CYCLES = washer_plant_model_pkg::FILL_CYCLES_DEF
);
  localparam int unsigned LEVEL_W = $clog2(FILL_CYCLES + 1);

  // actuators
  logic door_lock;
  logic motor_on;
  logic fill_value_on;
  logic drain_value_on;
  logic soap_wash;
  logic water_wash;
  logic done;

  // sensors
  logic               filled;
  logic               drained;
  logic               detergent_added;
  logic               cycle_timeout;
  logic               spin_timeout;
  logic [LEVEL_W-1:0] water_level;
  logic               fault;

  modport master (
    output door_lock, motor_on, fill_value_on, drain_value_on, soap_wash, water_wash, done,
    input  filled, drained, detergent_added, cycle_timeout, spin_timeout, water_level, fault
  );

  modport slave (
    input  door_lock, motor_on, fill_value_on, drain_value_on, soap_wash, water_wash, done,
    output filled, drained, detergent_added, cycle_timeout, spin_timeout, water_level, fault
  );

endinterface

// File: rtl/washer_plant_model_timer.sv
// Saturating elapsed-time counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : return count to zero (wins over enable_i)
//   enable_i   : advance one count per cycle, holding once tc_i is reached
//   tc_i       : terminal count
//   at_tc_o    : combinational, count currently equals tc_i
module washer_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             at_tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, else advance until the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != tc_i)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_tc_o = (cnt_q == tc_i);

endmodule

// File: rtl/washer_plant_model.sv
// Plant model closing the loop around the wash controller: integrates valve
// commands into a tank level, dispenses detergent, times wash and spin phases
// and latches interlock faults. All sensor outputs are registered.
//   clk, reset : clock, synchronous active-high reset
//   plant      : slave side of the actuator/sensor bundle
module washer_plant_model
  import washer_plant_model_pkg::*;
#(
  parameter int unsigned FILL_CYCLES = FILL_CYCLES_DEF,
  parameter int unsigned DET_CYCLES  = DET_CYCLES_DEF,
  parameter int unsigned WASH_CYCLES = WASH_CYCLES_DEF,
  parameter int unsigned SPIN_CYCLES = SPIN_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  washer_plant_model_if.slave plant
);

  localparam int unsigned LEVEL_W = $clog2(FILL_CYCLES + 1);
  localparam int unsigned DET_W   = $clog2(DET_CYCLES + 1);
  localparam int unsigned MT_MAX  = (WASH_CYCLES > SPIN_CYCLES) ? WASH_CYCLES : SPIN_CYCLES;
  localparam int unsigned MT_W    = $clog2(MT_MAX + 1);

  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FILL_CYCLES);
  localparam logic [DET_W-1:0]   DET_TC     = DET_W'(DET_CYCLES - 1);
  localparam logic [MT_W-1:0]    WASH_TC    = MT_W'(WASH_CYCLES - 1);
  localparam logic [MT_W-1:0]    SPIN_TC    = MT_W'(SPIN_CYCLES - 1);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic               filled_q, drained_q;
  logic               det_q, det_d;
  logic               cto_q, sto_q;
  logic               fault_q, fault_d;
  motor_state_t       state_q, state_d;

  logic            soap_run;
  logic            det_at_tc;
  logic            mt_clear, mt_enable, mt_at_tc;
  logic [MT_W-1:0] mt_tc;

  // Tank level: single valve moves the level one unit, saturating at both ends.
  always_comb begin
    level_d = level_q;
    if (plant.fill_value_on && !plant.drain_value_on && (level_q != LEVEL_FULL)) begin
      level_d = level_q + LEVEL_W'(1);
    end else if (plant.drain_value_on && !plant.fill_value_on && (level_q != '0)) begin
      level_d = level_q - LEVEL_W'(1);
    end
  end

  // Detergent dispenser: soap held against a full tank for DET_CYCLES cycles.
  assign soap_run = plant.soap_wash && filled_q;

  washer_timer #(.CNT_W(DET_W)) u_det_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (plant.done || !soap_run),
    .enable_i (soap_run),
    .tc_i     (DET_TC),
    .at_tc_o  (det_at_tc)
  );

  always_comb begin
    det_d = det_q;
    if (plant.done) begin
      det_d = 1'b0;
    end else if (soap_run && det_at_tc) begin
      det_d = 1'b1;
    end
  end

  // Motor mode next state; motor off always wins.
  always_comb begin
    state_d = state_q;
    if (!plant.motor_on) begin
      state_d = M_STOP;
    end else begin
      case (state_q)
        M_STOP: begin
          if (plant.drain_value_on)  state_d = M_SPIN;
          else if (filled_q)         state_d = M_WASH;
        end
        M_WASH: begin
          if (plant.drain_value_on)  state_d = M_SPIN;
          else if (mt_at_tc)         state_d = M_WASH_TO;
        end
        M_WASH_TO: begin
          if (plant.drain_value_on)  state_d = M_SPIN;
        end
        M_SPIN: begin
          if (mt_at_tc && drained_q) state_d = M_SPIN_TO;
        end
        M_SPIN_TO: state_d = M_SPIN_TO;
        default:   state_d = M_STOP;
      endcase
    end
  end

  // Shared wash/spin timer: restarts on every mode change; spin time only
  // accumulates while the tank reads empty.
  assign mt_clear  = (state_d != state_q);
  assign mt_enable = (state_q == M_WASH) || ((state_q == M_SPIN) && drained_q);
  assign mt_tc     = (state_q == M_SPIN) ? SPIN_TC : WASH_TC;

  washer_timer #(.CNT_W(MT_W)) u_motor_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (mt_clear),
    .enable_i (mt_enable),
    .tc_i     (mt_tc),
    .at_tc_o  (mt_at_tc)
  );

  // Interlock violations latch until reset.
  always_comb begin
    fault_d = fault_q;
    if ((plant.motor_on && !plant.door_lock) ||
        (plant.fill_value_on && plant.drain_value_on) ||
        (plant.fill_value_on && !plant.door_lock)) begin
      fault_d = 1'b1;
    end
  end

  // State and registered sensors; level flags decode the next level so they
  // move on the same edge as water_level.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= '0;
      filled_q  <= 1'b0;
      drained_q <= 1'b1;
      det_q     <= 1'b0;
      state_q   <= M_STOP;
      cto_q     <= 1'b0;
      sto_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      filled_q  <= (level_d == LEVEL_FULL);
      drained_q <= (level_d == '0);
      det_q     <= det_d;
      state_q   <= state_d;
      cto_q     <= (state_d == M_WASH_TO);
      sto_q     <= (state_d == M_SPIN_TO);
      fault_q   <= fault_d;
    end
  end

  assign plant.water_level     = level_q;
  assign plant.filled          = filled_q;
  assign plant.drained         = drained_q;
  assign plant.detergent_added = det_q;
  assign plant.cycle_timeout   = cto_q;
  assign plant.spin_timeout    = sto_q;
  assign plant.fault           = fault_q;

endmodule
